// File: rtl/ahb_arbiter_if.sv
// Bus-side signal bundle between the AHB masters and the arbiter.
// The master modport drives requests and transfer status; the slave modport is the arbiter itself.
interface ahb_arbiter_if;
  logic [3:0] hbusreq;
  logic [3:0] hlock;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic       hresp;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic       hmastlock;

  modport master (
    output hbusreq, hlock, htrans, hburst, hready, hresp,
    input  hgrant, hmaster, hmastlock
  );

  modport slave (
    input  hbusreq, hlock, htrans, hburst, hready, hresp,
    output hgrant, hmaster, hmastlock
  );
endinterface

// File: rtl/ahb_arbiter.sv
// Four-master AHB arbiter tracking fixed-length bursts and locked transfers.
// Define AHB_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (lowest index wins).
module ahb_arbiter #(
  parameter int DEFAULT_MASTER = 0
) (
  input logic          hclk,
  input logic          hreset,
  ahb_arbiter_if.slave bus
);

  localparam logic [1:0] DefIdx     = 2'(DEFAULT_MASTER);
  localparam logic [3:0] DefGrant   = 4'b0001 << DEFAULT_MASTER;
  localparam logic [1:0] TransIdle  = 2'd0;
  localparam logic [1:0] TransNonseq = 2'd2;
  localparam logic [1:0] TransSeq   = 2'd3;

  typedef enum logic [1:0] {ARB, BURST, LOCK} state_t;

  state_t     r_state;
  logic [3:0] r_grant;
  logic [1:0] r_master;
  logic       r_mastlock;
  logic [3:0] r_cnt;
  logic [1:0] r_rrPtr;

  state_t     w_stateNext;
  logic [3:0] w_grantNext;
  logic [1:0] w_masterNext;
  logic       w_mastlockNext;
  logic [3:0] w_cntNext;
  logic [1:0] w_ptrNext;
  logic [1:0] w_arbIdx;
  logic [1:0] w_nextIdx;
  logic       w_doArb;
  logic       w_burstStart;
  logic [3:0] w_burstLen;

  // The loop runs from the farthest candidate down so the nearest requester is assigned last.
  always_comb begin
    w_arbIdx = DefIdx;
`ifdef AHB_ARB_FIXED_PRIO_EN
    for (int i = 3; i >= 0; i--) begin
      if (bus.hbusreq[i]) w_arbIdx = 2'(i);
    end
`else
    for (int i = 3; i >= 0; i--) begin
      if (bus.hbusreq[r_rrPtr + 2'(i) + 2'd1]) w_arbIdx = r_rrPtr + 2'(i) + 2'd1;
    end
`endif
  end

  always_comb begin
    w_burstStart = (bus.htrans == TransNonseq) && (bus.hburst >= 3'd2);
    case (bus.hburst[2:1])
      2'b01:   w_burstLen = 4'd3;
      2'b10:   w_burstLen = 4'd7;
      2'b11:   w_burstLen = 4'd15;
      default: w_burstLen = 4'd0;
    endcase
  end

  // A burst-opening NONSEQ keeps the current grant; every other accepted ARB edge re-arbitrates.
  always_comb begin
    w_stateNext    = r_state;
    w_grantNext    = r_grant;
    w_masterNext   = r_master;
    w_mastlockNext = r_mastlock;
    w_cntNext      = r_cnt;
    w_ptrNext      = r_rrPtr;
    w_doArb        = 1'b0;
    w_nextIdx      = r_master;
    if (bus.hready) begin
      case (r_state)
        ARB: begin
          if (w_burstStart) begin
            w_stateNext = BURST;
            w_cntNext   = w_burstLen;
          end else begin
            w_doArb = 1'b1;
          end
        end
        BURST: begin
          if (bus.htrans == TransSeq) begin
            if (r_cnt <= 4'd1) w_doArb = 1'b1;
            else w_cntNext = r_cnt - 4'd1;
          end else if (bus.htrans == TransIdle) begin
            w_doArb = 1'b1;
          end
        end
        LOCK: begin
          if (!bus.hlock[r_master]) w_doArb = 1'b1;
        end
        default: w_doArb = 1'b1;
      endcase
      if (w_doArb) begin
        w_nextIdx   = w_arbIdx;
        w_grantNext = 4'b0001 << w_arbIdx;
        w_ptrNext   = w_arbIdx;
        w_cntNext   = 4'd0;
        w_stateNext = bus.hlock[w_arbIdx] ? LOCK : ARB;
      end
      w_masterNext   = w_nextIdx;
      w_mastlockNext = bus.hlock[w_nextIdx];
    end else if (bus.hresp && (r_state != ARB)) begin
      w_stateNext = ARB;
      w_cntNext   = 4'd0;
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state    <= ARB;
      r_grant    <= DefGrant;
      r_master   <= DefIdx;
      r_mastlock <= 1'b0;
      r_cnt      <= 4'd0;
      r_rrPtr    <= 2'd0;
    end else begin
      r_state    <= w_stateNext;
      r_grant    <= w_grantNext;
      r_master   <= w_masterNext;
      r_mastlock <= w_mastlockNext;
      r_cnt      <= w_cntNext;
      r_rrPtr    <= w_ptrNext;
    end
  end

  assign bus.hgrant    = r_grant;
  assign bus.hmaster   = r_master;
  assign bus.hmastlock = r_mastlock;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter (round-robin build, DEFAULT_MASTER = 0).
// Each table row is one clock: inputs driven at the falling edge, outputs checked just after the rising edge.
module tb_ahb_arbiter;

  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3;

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       ready;
    logic       resp;
    logic [3:0] expGrant;
    logic [1:0] expMaster;
    logic       expLock;
  } vec_t;

  logic hclk = 1'b0;
  logic hreset;
  int   testCount = 0;
  int   failCount = 0;
  vec_t vecs[$];

  ahb_arbiter_if bus();

  ahb_arbiter #(.DEFAULT_MASTER(0)) dut (
    .hclk  (hclk),
    .hreset(hreset),
    .bus   (bus)
  );

  always #5 hclk = ~hclk;

  function automatic vec_t mk(input logic [3:0] req, input logic [3:0] lock, input logic [1:0] tr,
                              input logic [2:0] bu, input logic rdy, input logic rsp,
                              input logic [3:0] g, input logic [1:0] m, input logic l);
    vec_t v;
    v.req = req; v.lock = lock; v.trans = tr; v.burst = bu; v.ready = rdy; v.resp = rsp;
    v.expGrant = g; v.expMaster = m; v.expLock = l;
    return v;
  endfunction

  task automatic driveInputs(input vec_t v);
    bus.hbusreq = v.req;
    bus.hlock   = v.lock;
    bus.htrans  = v.trans;
    bus.hburst  = v.burst;
    bus.hready  = v.ready;
    bus.hresp   = v.resp;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge hclk);
    driveInputs(v);
    @(posedge hclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] expGrant,
                             input logic [1:0] expMaster, input logic expLock);
    testCount++;
    if (bus.hgrant !== expGrant) begin
      failCount++;
      $display("[TB] FAIL %s hgrant got %b want %b", tag, bus.hgrant, expGrant);
    end
    testCount++;
    if (bus.hmaster !== expMaster) begin
      failCount++;
      $display("[TB] FAIL %s hmaster got %0d want %0d", tag, bus.hmaster, expMaster);
    end
    testCount++;
    if (bus.hmastlock !== expLock) begin
      failCount++;
      $display("[TB] FAIL %s hmastlock got %b want %b", tag, bus.hmastlock, expLock);
    end
    testCount++;
    if (!$onehot(bus.hgrant)) begin
      failCount++;
      $display("[TB] FAIL %s onehot got %b want one bit set", tag, bus.hgrant);
    end
  endtask

  initial begin
    // Reset release, hold with hready low, then first arbitration
    vecs.push_back(mk(4'b0110, 4'b0000, IDLE, 3'd0, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0110, 4'b0000, IDLE, 3'd0, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b0));
    // Round-robin rotation with all masters requesting
    vecs.push_back(mk(4'b1111, 4'b0000, IDLE, 3'd0, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0));
    vecs.push_back(mk(4'b1111, 4'b0000, IDLE, 3'd0, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b0));
    vecs.push_back(mk(4'b1111, 4'b0000, IDLE, 3'd0, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0));
    vecs.push_back(mk(4'b1111, 4'b0000, IDLE, 3'd0, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b0));
    // No requester falls back to the default master; hready low holds
    vecs.push_back(mk(4'b0000, 4'b0000, IDLE, 3'd0, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0));
    vecs.push_back(mk(4'b1000, 4'b0000, IDLE, 3'd0, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b0));
    vecs.push_back(mk(4'b1000, 4'b0000, IDLE, 3'd0, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b0));
    // INCR4 by master 2 with a BUSY beat; the third accepted SEQ hands over to master 0
    vecs.push_back(mk(4'b0100, 4'b0000, IDLE,   3'd0, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0101, 4'b0000, NONSEQ, 3'd3, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0101, 4'b0000, SEQ,    3'd3, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0101, 4'b0000, BUSY,   3'd3, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0101, 4'b0000, SEQ,    3'd3, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0101, 4'b0000, SEQ,    3'd3, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0));
    // INCR8 cut short by IDLE
    vecs.push_back(mk(4'b0101, 4'b0000, NONSEQ, 3'd5, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0101, 4'b0000, SEQ,    3'd5, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0101, 4'b0000, IDLE,   3'd5, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0));
    // INCR8 with two wait states on beat 3; releases only on the 7th accepted SEQ
    vecs.push_back(mk(4'b0011, 4'b0000, NONSEQ, 3'd5, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0011, 4'b0000, SEQ,    3'd5, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0011, 4'b0000, SEQ,    3'd5, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0011, 4'b0000, SEQ,    3'd5, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0011, 4'b0000, SEQ,    3'd5, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(4'b0011, 4'b0000, SEQ, 3'd5, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0011, 4'b0000, SEQ,    3'd5, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0));
    // INCR stays in arbitration mode
    vecs.push_back(mk(4'b0011, 4'b0000, NONSEQ, 3'd1, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b0));
    // Master 3 locks the bus until hlock drops on an hready edge
    vecs.push_back(mk(4'b1000, 4'b1000, IDLE,   3'd0, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b1000, IDLE,   3'd0, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b1000, NONSEQ, 3'd0, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b0000, IDLE,   3'd0, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b0000, IDLE,   3'd0, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0));
    // INCR16 aborted by an error response on beat 5
    vecs.push_back(mk(4'b0111, 4'b0000, NONSEQ, 3'd7, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(4'b0111, 4'b0000, SEQ, 3'd7, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0111, 4'b0000, SEQ,    3'd7, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0111, 4'b0000, SEQ,    3'd7, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b0));

    hreset = 1'b1;
    driveInputs(mk(4'b0110, 4'b0000, IDLE, 3'd0, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b0));
    repeat (2) @(posedge hclk);
    #1;
    checkOutput("reset", 4'b0001, 2'd0, 1'b0);
    @(negedge hclk);
    hreset = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].expGrant, vecs[i].expMaster, vecs[i].expLock);
    end

    // Asynchronous reset in the middle of a burst, then a SEQ must re-arbitrate from a clean state
    applyStimulus(mk(4'b0010, 4'b0000, NONSEQ, 3'd7, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b0));
    checkOutput("burstStart", 4'b0010, 2'd1, 1'b0);
    #2 hreset = 1'b1;
    #1 checkOutput("asyncRstBurst", 4'b0001, 2'd0, 1'b0);
    @(negedge hclk);
    hreset = 1'b0;
    driveInputs(mk(4'b0110, 4'b0000, SEQ, 3'd7, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0));
    @(posedge hclk);
    #1 checkOutput("postRstBurst", 4'b0010, 2'd1, 1'b0);

    // Asynchronous reset while master 0 holds a lock
    applyStimulus(mk(4'b0001, 4'b0001, IDLE, 3'd0, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1));
    checkOutput("lockStart", 4'b0001, 2'd0, 1'b1);
    #2 hreset = 1'b1;
    #1 checkOutput("asyncRstLock", 4'b0001, 2'd0, 1'b0);
    @(negedge hclk);
    hreset = 1'b0;
    driveInputs(mk(4'b0110, 4'b0001, IDLE, 3'd0, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0));
    @(posedge hclk);
    #1 checkOutput("postRstLock", 4'b0010, 2'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
